// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encoding and reset constants for the acquisition sequencer
package acq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LDCTRL   = 3'd1,
    S_CFG_WAIT = 3'd2,
    S_AGC      = 3'd3,
    S_SETTLE   = 3'd4,
    S_CLEAR    = 3'd5,
    S_RUN      = 3'd6,
    S_FAULT    = 3'd7
  } acq_state_t;

  localparam logic [9:0]  CTRLWORD_DEFAULT = 10'b0000100100;
  localparam logic [11:0] AGC_DEFAULT      = 12'h333;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/agc_update_gate.sv
// rtl/agc_update_gate.sv - holds AGC level updates and spaces SPI DAC writes by GAP cycles
module agc_update_gate #(
  parameter int GAP = 64
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        en,
  input  logic        reload,
  input  logic        update,
  input  logic [11:0] level,
  output logic        fire,
  output logic [11:0] data
);

  localparam int GW = $clog2(GAP + 1);

  logic [GW-1:0] gap;
  logic          pend;
  logic [11:0]   pend_val;
  logic          ready;

  // The load pulse is registered one cycle after this decision, so gap==1 already honours spacing.
  assign ready = (gap <= GW'(1));
  assign fire  = en && ready && (pend || update);
  assign data  = update ? level : pend_val;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      gap      <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      if (reload || fire) begin
        gap <= GW'(GAP);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end

      if (!en || fire) begin
        pend <= 1'b0;
      end else if (update) begin
        pend <= 1'b1;
      end

      if (en && update) begin
        pend_val <= level;
      end
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - master acquisition sequencer: ADC config, AGC load, settle, FIFO clear, run
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 1000,
  parameter int          BUSY_TIMEOUT  = 4096,
  parameter int          AGC_GAP       = 64,
  parameter logic [9:0]  CTRLWORD_RST  = CTRLWORD_DEFAULT,
  parameter logic [11:0] AGC_RST       = AGC_DEFAULT
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        stop,
  input  logic [9:0]  ctrlword_in,
  input  logic [11:0] agc_level,
  input  logic        agc_update,
  input  logic        mbusy_i,
  input  logic        mbusy_q,
  input  logic        fifo_full,
  output logic        adc_ldctrl,
  output logic [9:0]  adc_ctrlword,
  output logic        adc_enable,
  output logic        agc_load,
  output logic [11:0] agc_data,
  output logic        fifo_clr,
  output logic        running,
  output logic        overflow,
  output logic        timeout_err,
  output logic [2:0]  state
);

  localparam int CNT_W = max2($clog2(BUSY_TIMEOUT + 1), $clog2(SETTLE_CYCLES + 1));
  localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  acq_state_t       state_r, next_state;
  logic [CNT_W-1:0] cnt;
  logic             accept_start;
  logic             gate_fire;
  logic [11:0]      gate_data;
  logic             ldctrl_d, agc_load_d, clr_d, run_d, ovf_d, to_d;
  logic [9:0]       ctrlword_d;
  logic [11:0]      agc_data_d;

  assign accept_start = start && !stop && (state_r == S_IDLE || state_r == S_FAULT);
  assign state        = state_r;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  always_comb begin
    next_state = state_r;
    if (stop && state_r != S_IDLE) begin
      next_state = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:     if (start) next_state = S_LDCTRL;
        S_LDCTRL:   next_state = S_CFG_WAIT;
        // First CFG_WAIT cycle is blind: the ADC interfaces have not yet raised mbusy.
        S_CFG_WAIT: begin
          if (cnt != '0 && !mbusy_i && !mbusy_q) next_state = S_AGC;
          else if (cnt >= BUSY_LAST)             next_state = S_FAULT;
        end
        S_AGC:      next_state = S_SETTLE;
        S_SETTLE:   if (cnt >= SETTLE_LAST) next_state = S_CLEAR;
        S_CLEAR:    next_state = S_RUN;
        S_RUN:      if (fifo_full) next_state = S_FAULT;
        S_FAULT:    if (start) next_state = S_LDCTRL;
        default:    next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (next_state != state_r) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  agc_update_gate #(.GAP(AGC_GAP)) u_gate (
    .clk    (clk),
    .arst   (arst),
    .en     (state_r == S_RUN && next_state == S_RUN),
    .reload (next_state == S_AGC),
    .update (agc_update),
    .level  (agc_level),
    .fire   (gate_fire),
    .data   (gate_data)
  );

  always_comb begin
    ldctrl_d   = (next_state == S_LDCTRL);
    agc_load_d = (next_state == S_AGC) || gate_fire;
    clr_d      = (next_state == S_CLEAR);
    run_d      = (next_state == S_RUN);
    ovf_d      = overflow;
    to_d       = timeout_err;
    ctrlword_d = adc_ctrlword;
    agc_data_d = agc_data;
    if (accept_start) begin
      ovf_d      = 1'b0;
      to_d       = 1'b0;
      ctrlword_d = ctrlword_in;
      agc_data_d = agc_level;
    end else begin
      if (state_r == S_RUN && next_state == S_FAULT)      ovf_d = 1'b1;
      if (state_r == S_CFG_WAIT && next_state == S_FAULT) to_d  = 1'b1;
      if (gate_fire) agc_data_d = gate_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      adc_ldctrl   <= 1'b0;
      agc_load     <= 1'b0;
      fifo_clr     <= 1'b0;
      adc_enable   <= 1'b0;
      running      <= 1'b0;
      overflow     <= 1'b0;
      timeout_err  <= 1'b0;
      adc_ctrlword <= CTRLWORD_RST;
      agc_data     <= AGC_RST;
    end else begin
      adc_ldctrl   <= ldctrl_d;
      agc_load     <= agc_load_d;
      fifo_clr     <= clr_d;
      adc_enable   <= run_d;
      running      <= run_d;
      overflow     <= ovf_d;
      timeout_err  <= to_d;
      adc_ctrlword <= ctrlword_d;
      agc_data     <= agc_data_d;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - directed table-driven bench for acq_sequencer
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic        start, stop, agc_update, mbusy_i, mbusy_q, fifo_full;
  logic [9:0]  ctrlword_in;
  logic [11:0] agc_level;
  logic        adc_ldctrl, adc_enable, agc_load, fifo_clr, running, overflow, timeout_err;
  logic [9:0]  adc_ctrlword;
  logic [11:0] agc_data;
  logic [2:0]  state;

  always #5 clk = ~clk;

  acq_sequencer #(
    .SETTLE_CYCLES (10),
    .BUSY_TIMEOUT  (50),
    .AGC_GAP       (64),
    .CTRLWORD_RST  (10'b0000100100),
    .AGC_RST       (12'h333)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .start        (start),
    .stop         (stop),
    .ctrlword_in  (ctrlword_in),
    .agc_level    (agc_level),
    .agc_update   (agc_update),
    .mbusy_i      (mbusy_i),
    .mbusy_q      (mbusy_q),
    .fifo_full    (fifo_full),
    .adc_ldctrl   (adc_ldctrl),
    .adc_ctrlword (adc_ctrlword),
    .adc_enable   (adc_enable),
    .agc_load     (agc_load),
    .agc_data     (agc_data),
    .fifo_clr     (fifo_clr),
    .running      (running),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .state        (state)
  );

  typedef struct {
    logic       start, stop, ff, mbq, quiet;
    int         adv;
    logic [2:0] st;
    logic       ld, al, clr, en, ovf, to;
  } vec_t;

  vec_t v[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    fifo_full = 1'b0;
    agc_update = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic p, input logic f, input logic b,
                              input logic q, input int a, input logic [2:0] st,
                              input logic ld, input logic al, input logic clr,
                              input logic en, input logic ovf, input logic to);
    vec_t r;
    r.start = s; r.stop = p; r.ff = f; r.mbq = b; r.quiet = q; r.adv = a;
    r.st = st; r.ld = ld; r.al = al; r.clr = clr; r.en = en; r.ovf = ovf; r.to = to;
    return r;
  endfunction

  vec_t e;
  int   qbad, wt, nl;
  int   lc[4];
  logic [11:0] ldat[4];

  initial begin
    //               st p  ff mq qt adv  state ld al cl en ov to
    v.push_back(mk(0, 0, 0, 0, 1, 3,  3'd0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 1,  3'd1, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd2, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd2, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd3, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd4, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 9,  3'd4, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd5, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,  3'd6, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 5,  3'd6, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 1,  3'd7, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 3,  3'd7, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 1, 0, 1,  3'd1, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 1,  3'd2, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 1, 49, 3'd2, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 1,  3'd7, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 4,  3'd7, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 1,  3'd0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 0, 0, 0, 0, 1,  3'd1, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 4,  3'd4, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 0, 0, 1,  3'd0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 15, 3'd0, 0, 0, 0, 0, 0, 0));

    arst = 1'b1;
    start = 0; stop = 0; agc_update = 0; mbusy_i = 0; mbusy_q = 0; fifo_full = 0;
    ctrlword_in = 10'h1A5;
    agc_level = 12'h333;
    repeat (3) @(posedge clk);
    #2 arst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrlword", 32'(adc_ctrlword), 32'h024);
    chk("rst_agc_data", 32'(agc_data), 32'h333);
    chk("rst_flags", 32'({adc_ldctrl, agc_load, fifo_clr, adc_enable, running, overflow, timeout_err}), 32'd0);

    for (int i = 0; i < v.size(); i++) begin
      e = v[i];
      start = e.start; stop = e.stop; fifo_full = e.ff; mbusy_q = e.mbq;
      qbad = 0;
      for (int k = 0; k < e.adv; k++) begin
        tick();
        if (adc_ldctrl || agc_load || fifo_clr || adc_enable) qbad++;
      end
      if (e.quiet) chk($sformatf("v%0d_quiet", i), 32'(qbad), 32'd0);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(e.st));
      chk($sformatf("v%0d_ldctrl", i), 32'(adc_ldctrl), 32'(e.ld));
      chk($sformatf("v%0d_agc_load", i), 32'(agc_load), 32'(e.al));
      chk($sformatf("v%0d_fifo_clr", i), 32'(fifo_clr), 32'(e.clr));
      chk($sformatf("v%0d_enable", i), 32'(adc_enable), 32'(e.en));
      chk($sformatf("v%0d_running", i), 32'(running), 32'(e.en));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(e.ovf));
      chk($sformatf("v%0d_timeout", i), 32'(timeout_err), 32'(e.to));
    end
    chk("latched_ctrlword", 32'(adc_ctrlword), 32'h1A5);
    chk("latched_agc_data", 32'(agc_data), 32'h333);

    // AGC update merging: 0x100 fires at once, 0x200/0x300 merge into one write a full gap later.
    agc_level = 12'h0F0;
    ctrlword_in = 10'h2C3;
    start = 1'b1;
    wt = 0;
    while (!running && wt < 100) begin
      tick();
      wt++;
    end
    chk("agc_run_reached", 32'(running), 32'd1);
    chk("agc_data_start", 32'(agc_data), 32'h0F0);
    chk("ctrlword_start", 32'(adc_ctrlword), 32'h2C3);
    repeat (70) tick();
    nl = 0;
    for (int k = 0; k < 4; k++) begin
      lc[k] = 0;
      ldat[k] = '0;
    end
    for (int k = 0; k < 150; k++) begin
      if (k == 0) begin agc_update = 1'b1; agc_level = 12'h100; end
      if (k == 3) begin agc_update = 1'b1; agc_level = 12'h200; end
      if (k == 6) begin agc_update = 1'b1; agc_level = 12'h300; end
      tick();
      if (agc_load) begin
        if (nl < 4) begin
          lc[nl] = k + 1;
          ldat[nl] = agc_data;
        end
        nl++;
      end
    end
    chk("agc_load_count", 32'(nl), 32'd2);
    chk("agc_first_cycle", 32'(lc[0]), 32'd1);
    chk("agc_first_data", 32'(ldat[0]), 32'h100);
    chk("agc_spacing", 32'(lc[1] - lc[0]), 32'd64);
    chk("agc_second_data", 32'(ldat[1]), 32'h300);

    // Asynchronous reset in RUN: outputs must drop before the next clock edge.
    chk("arst_pre_running", 32'(running), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_flags", 32'({adc_ldctrl, agc_load, fifo_clr, adc_enable, running, overflow, timeout_err}), 32'd0);
    chk("arst_ctrlword", 32'(adc_ctrlword), 32'h024);
    chk("arst_agc_data", 32'(agc_data), 32'h333);
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    qbad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (adc_ldctrl || agc_load || fifo_clr || adc_enable || running) qbad++;
    end
    chk("post_arst_quiet", 32'(qbad), 32'd0);
    chk("post_arst_state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
